// File: rtl/dmem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// dmem_access_unit_pkg
// Shared definitions for the MEM-stage load/store access unit:
//   - WCONV_* access width codes, shared with the load width converter
//   - FSM state encoding for the access controller
//   - byte-enable constants for word and half-word accesses
//   - is_aligned(): natural-alignment check for a width/byte-position pair
// ---------------------------------------------------------------------------
package dmem_access_unit_pkg;

  // Width codes as consumed by the load width converter; 2'b11 is unused.
  localparam logic [1:0] WCONV_WORD = 2'b00;
  localparam logic [1:0] WCONV_HALF = 2'b01;
  localparam logic [1:0] WCONV_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // The unused width code counts as misaligned so it never reaches the bus.
  function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] pos);
    case (width)
      WCONV_WORD: return (pos == 2'b00);
      WCONV_HALF: return !pos[0];
      WCONV_BYTE: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// ---------------------------------------------------------------------------
// dmem_access_unit_if
// Data-memory bus between the access unit (master) and the memory (slave).
//   bus_req   : request, held until bus_ack
//   bus_we    : write strobe
//   bus_addr  : word-aligned byte address
//   bus_be    : byte enables
//   bus_wdata : lane-replicated store data
//   bus_ack   : memory completes the access this cycle
//   bus_rdata : read word, valid with bus_ack
// ---------------------------------------------------------------------------
interface dmem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_access_unit_store_align.sv
// ---------------------------------------------------------------------------
// dmem_store_align
// Combinational store formatter.
//   width_i : WCONV_* access width
//   pos_i   : byte position within the word (addr[1:0])
//   wdata_i : right-justified store data
//   be_o    : byte enables for the addressed lanes
//   wdata_o : store data replicated across all lanes, so the enabled lanes
//             always carry the right bytes whatever the position
// ---------------------------------------------------------------------------
module dmem_store_align
  import dmem_access_unit_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic [1:0]  pos_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o = 4'b0000;
    case (width_i)
      WCONV_WORD: be_o = BE_WORD;
      WCONV_HALF: be_o = pos_i[1] ? BE_HALF_HI : BE_HALF_LO;
      WCONV_BYTE: be_o = 4'b0001 << pos_i;
      default:    be_o = 4'b0000;
    endcase
  end

  // Lane gi takes byte 0 for byte stores, byte gi%2 for half stores
  // (giving {d[15:0], d[15:0]}), and its own byte for word stores.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : lane_g
      assign wdata_o[8*gi +: 8] =
        (width_i == WCONV_BYTE) ? wdata_i[7:0] :
        (width_i == WCONV_HALF) ? wdata_i[8*(gi%2) +: 8] :
                                  wdata_i[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
// MEM-stage load/store controller feeding the load width converter.
// Checks alignment, issues one req/ack access on the data-memory bus while
// stalling the pipeline, then presents the raw read word with its width,
// sign and byte position for one cycle.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_*_i         : pipeline memory op (valid, we, width, sign, addr, wdata)
//   req_ready_o     : unit idle and able to accept
//   stall_o         : freeze upstream pipeline
//   bus             : data-memory bus (master side)
//   resp_*_o        : one-cycle completion (valid, we, rdata, width, sign, pos)
//   err_align_o     : one-cycle misalignment pulse
//   err_timeout_o   : one-cycle bus timeout pulse
// ---------------------------------------------------------------------------
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_width_i,
  input  logic              req_sign_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              req_ready_o,
  output logic              stall_o,
  dmem_access_unit_if.master bus,
  output logic              resp_valid_o,
  output logic              resp_we_o,
  output logic [31:0]       resp_rdata_o,
  output logic [1:0]        resp_width_o,
  output logic              resp_sign_o,
  output logic [1:0]        resp_pos_o,
  output logic              err_align_o,
  output logic              err_timeout_o
);

  // Counter value seen on the last permitted WAIT cycle.
  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [31:0]       bus_wdata_q;
  logic              we_q;
  logic [1:0]        width_q;
  logic              sign_q;
  logic [1:0]        pos_q;
  logic [31:0]       rdata_q;
  logic              resp_valid_q;
  logic              err_align_q;
  logic              err_timeout_q;

  logic              aligned_d;
  logic              accept_d;
  logic [3:0]        st_be_d;
  logic [31:0]       st_wdata_d;

  dmem_store_align u_store_align (
    .width_i (req_width_i),
    .pos_i   (req_addr_i[1:0]),
    .wdata_i (req_wdata_i),
    .be_o    (st_be_d),
    .wdata_o (st_wdata_d)
  );

  assign aligned_d   = is_aligned(req_width_i, req_addr_i[1:0]);
  assign accept_d    = (state_q == IDLE) && req_valid_i && aligned_d;
  assign req_ready_o = (state_q == IDLE);
  assign stall_o     = accept_d || (state_q == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      we_q          <= 1'b0;
      width_q       <= '0;
      sign_q        <= 1'b0;
      pos_q         <= '0;
      rdata_q       <= '0;
      resp_valid_q  <= 1'b0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      resp_valid_q  <= 1'b0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            if (!aligned_d) begin
              err_align_q <= 1'b1;
            end else begin
              state_q     <= WAIT;
              cnt_q       <= '0;
              bus_req_q   <= 1'b1;
              bus_we_q    <= req_we_i;
              bus_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              // Loads read the whole word; the width converter picks lanes.
              bus_be_q    <= req_we_i ? st_be_d : BE_WORD;
              bus_wdata_q <= req_we_i ? st_wdata_d : 32'd0;
              we_q        <= req_we_i;
              width_q     <= req_width_i;
              sign_q      <= req_sign_i;
              pos_q       <= req_addr_i[1:0];
            end
          end
        end
        WAIT: begin
          // Ack is tested first so that an ack on the last cycle wins.
          if (bus.bus_ack) begin
            bus_req_q    <= 1'b0;
            rdata_q      <= we_q ? 32'd0 : bus.bus_rdata;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            bus_req_q     <= 1'b0;
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end
          cnt_q <= cnt_q + 8'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

  assign resp_valid_o  = resp_valid_q;
  assign resp_we_o     = we_q;
  assign resp_rdata_o  = rdata_q;
  assign resp_width_o  = width_q;
  assign resp_sign_o   = sign_q;
  assign resp_pos_o    = pos_q;
  assign err_align_o   = err_align_q;
  assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_unit
// Directed and randomized load/store operations against a behavioural model
// of the access unit (size/alignment arithmetic, expected cycle timeline).
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;

  localparam int TB_MAX_WAIT = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_width;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic        resp_we;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_width;
  logic        resp_sign;
  logic [1:0]  resp_pos;
  logic        err_align;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;
  int txn_no   = 0;

  dmem_access_unit_if #(.ADDR_W(32)) bus_if ();

  dmem_access_unit #(
    .ADDR_W   (32),
    .MAX_WAIT (TB_MAX_WAIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_we_i      (req_we),
    .req_width_i   (req_width),
    .req_sign_i    (req_sign),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_ready_o   (req_ready),
    .stall_o       (stall),
    .bus           (bus_if),
    .resp_valid_o  (resp_valid),
    .resp_we_o     (resp_we),
    .resp_rdata_o  (resp_rdata),
    .resp_width_o  (resp_width),
    .resp_sign_o   (resp_sign),
    .resp_pos_o    (resp_pos),
    .err_align_o   (err_align),
    .err_timeout_o (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (txn %0d)", tag, got, exp, txn_no);
    end
  endtask

  // ---- reference model: plain arithmetic on access size ----
  function automatic int acc_size(input logic [1:0] w);
    case (w)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic model_aligned(input logic [1:0] w, input logic [31:0] a);
    int sz = acc_size(w);
    if (sz == 0) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [1:0] w, input logic [31:0] a);
    int sz = acc_size(w);
    if (!we) return 4'hF;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic we, input logic [1:0] w, input logic [31:0] d);
    if (!we) return 32'd0;
    case (acc_size(w))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // One operation. ack_at = WAIT cycle (1-based) on which memory acks;
  // 0 or > TB_MAX_WAIT means memory never answers.
  task automatic run_op(input logic we, input logic [1:0] w, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_at);
    logic ok;
    logic acked;
    int   k;
    ok    = model_aligned(w, addr);
    acked = 1'b0;
    txn_no++;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_width = w; req_sign = sgn;
    req_addr = addr; req_wdata = wd;
    #1;
    chk("ready_idle", 32'(req_ready), 32'd1);
    chk("stall_accept", 32'(stall), 32'(ok));
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    if (!ok) begin
      chk("err_align_pulse", 32'(err_align), 32'd1);
      chk("no_bus_req_mis", 32'(bus_if.bus_req), 32'd0);
      chk("ready_after_mis", 32'(req_ready), 32'd1);
      @(negedge clk); #1;
      chk("err_align_end", 32'(err_align), 32'd0);
      chk("no_resp_mis", 32'(resp_valid), 32'd0);
      $display("txn %0d we=%0d width=%0d addr=%h misaligned", txn_no, we, w, addr);
      return;
    end
    k = 1;
    while (!acked && k <= TB_MAX_WAIT) begin
      chk("bus_req", 32'(bus_if.bus_req), 32'd1);
      chk("bus_we", 32'(bus_if.bus_we), 32'(we));
      chk("bus_addr", bus_if.bus_addr, addr & 32'hFFFF_FFFC);
      chk("bus_be", 32'(bus_if.bus_be), 32'(model_be(we, w, addr)));
      chk("bus_wdata", bus_if.bus_wdata, model_wdata(we, w, wd));
      chk("stall_wait", 32'(stall), 32'd1);
      chk("ready_wait", 32'(req_ready), 32'd0);
      chk("resp_wait", 32'(resp_valid), 32'd0);
      // Requests while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = $urandom & 32'hFFFF_FFFC;
      req_width = 2'b00;
      if (k == ack_at) begin
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rd; acked = 1'b1;
      end else begin
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;
      end
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      req_valid = 1'b0;
      #1;
      k++;
    end
    if (acked) begin
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_we", 32'(resp_we), 32'(we));
      chk("resp_rdata", resp_rdata, we ? 32'd0 : rd);
      chk("resp_width", 32'(resp_width), 32'(w));
      chk("resp_sign", 32'(resp_sign), 32'(sgn));
      chk("resp_pos", 32'(resp_pos), addr % 4);
      chk("stall_resp", 32'(stall), 32'd0);
      chk("bus_req_drop", 32'(bus_if.bus_req), 32'd0);
      chk("no_timeout", 32'(err_timeout), 32'd0);
      @(negedge clk); #1;
      chk("resp_one_cycle", 32'(resp_valid), 32'd0);
      chk("ready_after_resp", 32'(req_ready), 32'd1);
    end else begin
      chk("err_timeout", 32'(err_timeout), 32'd1);
      chk("bus_req_to", 32'(bus_if.bus_req), 32'd0);
      chk("ready_to", 32'(req_ready), 32'd1);
      chk("no_resp_to", 32'(resp_valid), 32'd0);
      @(negedge clk); #1;
      chk("err_timeout_end", 32'(err_timeout), 32'd0);
    end
    $display("txn %0d we=%0d width=%0d addr=%h ack_at=%0d %s", txn_no, we, w, addr,
             ack_at, acked ? "done" : "timeout");
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_width = 2'b00; req_sign = 1'b0;
    req_addr = '0; req_wdata = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_bus_be", 32'(bus_if.bus_be), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 1);
    run_op(1'b1, 2'b10, 1'b0, 32'h0000_2003, 32'h0000_00A5, 32'd0, 3);
    run_op(1'b0, 2'b01, 1'b1, 32'h0000_3002, 32'd0, 32'h8001_0000, 1);
    run_op(1'b0, 2'b01, 1'b0, 32'h0000_3001, 32'd0, 32'd0, 1);
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_3002, 32'd0, 32'd0, 1);
    run_op(1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'd0, 32'd0, 1);
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'd0, 32'h1234_5678, 0);
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'd0, 32'h1234_5678, TB_MAX_WAIT);
    run_op(1'b1, 2'b01, 1'b0, 32'h0000_5002, 32'hCAFE_1234, 32'd0, 2);

    // Reset in the middle of WAIT
    txn_no++;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = 2'b00; req_addr = 32'h0000_6000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("arst_bus_addr", bus_if.bus_addr, 32'd0);
    chk("arst_resp", 32'(resp_valid), 32'd0);
    chk("arst_to", 32'(err_timeout), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_no_pulse", 32'(err_timeout | err_align | resp_valid), 32'd0);
    $display("txn %0d reset during WAIT", txn_no);
    run_op(1'b0, 2'b10, 1'b1, 32'h0000_7001, 32'd0, 32'h55AA_33CC, 1);

    // Randomized operations
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  w;
      logic [31:0] a;
      int          sz;
      w  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom;
      sz = acc_size(w);
      if (sz != 0 && $urandom_range(0, 3) != 0) a = a - (a % sz);
      // Occasional idle cycle with a stray ack, which must be ignored.
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus_if.bus_ack = 1'b1;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        #1;
        chk("stray_ack", 32'(resp_valid | bus_if.bus_req), 32'd0);
      end
      run_op(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom, $urandom_range(1, TB_MAX_WAIT + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
